// File: rtl/ddr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ddr_arbiter: burst-atomic round-robin sharing of one DDRAM port by 3 clients.
// Rev 1.0 -- define DDR_ARB_TIMEOUT_EN to enable the read-burst watchdog.
// ============================================================================
module ddr_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int BURST_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_sys,
  input  logic                    RESET,
  // requester 0: ROM download writer
  input  logic                    req_rd_0,
  input  logic                    req_wr_0,
  input  logic [ADDR_WIDTH-1:0]   req_addr_0,
  input  logic [BURST_WIDTH-1:0]  req_burst_0,
  input  logic [DATA_WIDTH-1:0]   req_din_0,
  input  logic [DATA_WIDTH/8-1:0] req_mask_0,
  output logic                    req_wait_0,
  output logic                    req_valid_0,
  // requester 1: frame buffer writer
  input  logic                    req_rd_1,
  input  logic                    req_wr_1,
  input  logic [ADDR_WIDTH-1:0]   req_addr_1,
  input  logic [BURST_WIDTH-1:0]  req_burst_1,
  input  logic [DATA_WIDTH-1:0]   req_din_1,
  input  logic [DATA_WIDTH/8-1:0] req_mask_1,
  output logic                    req_wait_1,
  output logic                    req_valid_1,
  // requester 2: ROM/tile reader
  input  logic                    req_rd_2,
  input  logic                    req_wr_2,
  input  logic [ADDR_WIDTH-1:0]   req_addr_2,
  input  logic [BURST_WIDTH-1:0]  req_burst_2,
  input  logic [DATA_WIDTH-1:0]   req_din_2,
  input  logic [DATA_WIDTH/8-1:0] req_mask_2,
  output logic                    req_wait_2,
  output logic                    req_valid_2,
  output logic [DATA_WIDTH-1:0]   req_dout,
  // DDRAM port
  output logic                    ddr_rd,
  output logic                    ddr_wr,
  output logic [ADDR_WIDTH-1:0]   ddr_addr,
  output logic [BURST_WIDTH-1:0]  ddr_burst,
  output logic [DATA_WIDTH-1:0]   ddr_din,
  output logic [DATA_WIDTH/8-1:0] ddr_mask,
  input  logic                    ddr_busy,
  input  logic                    ddr_valid,
  input  logic [DATA_WIDTH-1:0]   ddr_dout,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              grant_q, grant_d;
  logic [1:0]              last_grant_q, last_grant_d;
  logic [BURST_WIDTH-1:0]  cnt_q, cnt_d;
  logic [BURST_WIDTH-1:0]  burst_q, burst_d;

  logic [2:0]              req_v, wait_v, valid_v, gmask;
  logic [1:0]              next_grant;
  logic                    sel_rd, sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [BURST_WIDTH-1:0]  sel_burst, burst_eff;
  logic [DATA_WIDTH-1:0]   sel_din;
  logic [DATA_WIDTH/8-1:0] sel_mask;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

`ifdef DDR_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign req_v = {req_rd_2 | req_wr_2, req_rd_1 | req_wr_1, req_rd_0 | req_wr_0};
  assign gmask = 3'b001 << grant_q;
  assign burst_eff = (sel_burst == '0) ? BURST_WIDTH'(1) : sel_burst;

  always_comb begin
    sel_rd    = req_rd_2;
    sel_wr    = req_wr_2;
    sel_addr  = req_addr_2;
    sel_burst = req_burst_2;
    sel_din   = req_din_2;
    sel_mask  = req_mask_2;
    case (grant_q)
      2'd0: begin
        sel_rd    = req_rd_0;
        sel_wr    = req_wr_0;
        sel_addr  = req_addr_0;
        sel_burst = req_burst_0;
        sel_din   = req_din_0;
        sel_mask  = req_mask_0;
      end
      2'd1: begin
        sel_rd    = req_rd_1;
        sel_wr    = req_wr_1;
        sel_addr  = req_addr_1;
        sel_burst = req_burst_1;
        sel_din   = req_din_1;
        sel_mask  = req_mask_1;
      end
      default: ;
    endcase
  end

  // search starts at the requester after the previous winner
  always_comb begin
    next_grant = 2'd0;
    case (last_grant_q)
      2'd0:    next_grant = req_v[1] ? 2'd1 : (req_v[2] ? 2'd2 : 2'd0);
      2'd1:    next_grant = req_v[2] ? 2'd2 : (req_v[0] ? 2'd0 : 2'd1);
      default: next_grant = req_v[0] ? 2'd0 : (req_v[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    burst_d      = burst_q;
`ifdef DDR_ARB_TIMEOUT_EN
    wd_d         = wd_q;
    err_d        = err_q;
`endif
    ddr_rd    = 1'b0;
    ddr_wr    = 1'b0;
    ddr_addr  = sel_addr;
    ddr_burst = burst_eff;
    ddr_din   = sel_din;
    ddr_mask  = sel_mask;
    wait_v    = 3'b111;
    valid_v   = 3'b000;

    case (state_q)
      S_IDLE: begin
        if (|req_v) begin
          grant_d      = next_grant;
          last_grant_d = next_grant;
          state_d      = S_CMD;
        end
      end
      S_CMD: begin
        ddr_rd = sel_rd;
        ddr_wr = sel_wr & ~sel_rd;
        wait_v = ~gmask | {3{ddr_busy}};
        if (!sel_rd && !sel_wr) begin
          state_d = S_IDLE;
        end else if (!ddr_busy) begin
          if (sel_rd) begin
            cnt_d   = burst_eff;
            state_d = S_READ;
`ifdef DDR_ARB_TIMEOUT_EN
            wd_d    = '0;
`endif
          end else begin
            cnt_d   = burst_eff - BURST_WIDTH'(1);
            burst_d = burst_eff;
            state_d = (burst_eff == BURST_WIDTH'(1)) ? S_IDLE : S_WRITE;
          end
        end
      end
      S_READ: begin
        valid_v = gmask & {3{ddr_valid}};
        if (ddr_valid) begin
          cnt_d = cnt_q - BURST_WIDTH'(1);
          if (cnt_q == BURST_WIDTH'(1)) state_d = S_IDLE;
        end
`ifdef DDR_ARB_TIMEOUT_EN
        wd_d = wd_q + WD_W'(1);
        if (!(ddr_valid && cnt_q == BURST_WIDTH'(1)) && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
`endif
      end
      S_WRITE: begin
        // the burst count seen by the DDR must stay at the first-beat value
        ddr_wr    = sel_wr;
        ddr_burst = burst_q;
        wait_v    = ~gmask | {3{ddr_busy}};
        if (sel_wr && !ddr_busy) begin
          cnt_d = cnt_q - BURST_WIDTH'(1);
          if (cnt_q == BURST_WIDTH'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd2;
      cnt_q        <= '0;
      burst_q      <= '0;
`ifdef DDR_ARB_TIMEOUT_EN
      wd_q         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      burst_q      <= burst_d;
`ifdef DDR_ARB_TIMEOUT_EN
      wd_q         <= wd_d;
      err_q        <= err_d;
`endif
    end
  end

  assign {req_wait_2, req_wait_1, req_wait_0}    = wait_v;
  assign {req_valid_2, req_valid_1, req_valid_0} = valid_v;
  assign req_dout = ddr_dout;

endmodule
`default_nettype wire

// File: tb/tb_ddr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_ddr_arbiter: directed vector table plus hand sequences for ddr_arbiter.
// Rev 1.0
// ============================================================================
module tb_ddr_arbiter;

  logic        clk_sys = 1'b0;
  logic        RESET   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  logic [2:0]  rd, wr;
  logic [7:0]  bst;
  logic        busy, dvalid;
  logic [63:0] ddr_dout;
  logic [2:0]  wt, vl;
  logic        ddr_rd, ddr_wr, timeout_err;
  logic [31:0] ddr_addr;
  logic [7:0]  ddr_burst, ddr_mask;
  logic [63:0] ddr_din, req_dout;

  logic [31:0] c_addr [3];
  logic [63:0] c_din  [3];
  logic [7:0]  c_mask [3];

  int n_tests = 0;
  int n_fail  = 0;

  ddr_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .BURST_WIDTH(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_sys(clk_sys), .RESET(RESET),
    .req_rd_0(rd[0]), .req_wr_0(wr[0]), .req_addr_0(c_addr[0]), .req_burst_0(bst),
    .req_din_0(c_din[0]), .req_mask_0(c_mask[0]), .req_wait_0(wt[0]), .req_valid_0(vl[0]),
    .req_rd_1(rd[1]), .req_wr_1(wr[1]), .req_addr_1(c_addr[1]), .req_burst_1(bst),
    .req_din_1(c_din[1]), .req_mask_1(c_mask[1]), .req_wait_1(wt[1]), .req_valid_1(vl[1]),
    .req_rd_2(rd[2]), .req_wr_2(wr[2]), .req_addr_2(c_addr[2]), .req_burst_2(bst),
    .req_din_2(c_din[2]), .req_mask_2(c_mask[2]), .req_wait_2(wt[2]), .req_valid_2(vl[2]),
    .req_dout(req_dout),
    .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_addr(ddr_addr), .ddr_burst(ddr_burst),
    .ddr_din(ddr_din), .ddr_mask(ddr_mask), .ddr_busy(busy), .ddr_valid(dvalid),
    .ddr_dout(ddr_dout), .timeout_err(timeout_err)
  );

  typedef struct {
    int         tid;
    bit         rst;
    logic [2:0] rd, wr;
    logic [7:0] bst;
    logic       busy, valid;
    logic [1:0] cmd;     // {ddr_rd, ddr_wr}
    logic [2:0] wt, vl;
    logic       err;
    bit         chk;     // also check the muxed address/data/mask/burst
    logic [1:0] g;
    logic [7:0] ebst;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int tid, input bit rst, input logic [2:0] r, input logic [2:0] w,
                     input logic [7:0] b, input logic bz, input logic va, input logic [1:0] cmd,
                     input logic [2:0] wte, input logic [2:0] vle, input logic erre,
                     input bit chk, input logic [1:0] g, input logic [7:0] eb);
    vec_t v;
    v.tid = tid; v.rst = rst; v.rd = r; v.wr = w; v.bst = b; v.busy = bz; v.valid = va;
    v.cmd = cmd; v.wt = wte; v.vl = vle; v.err = erre; v.chk = chk; v.g = g; v.ebst = eb;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    RESET = 1'b1; rd = '0; wr = '0; bst = '0; busy = 1'b0; dvalid = 1'b0;
    #1;
    check("reset state", 128'({ddr_rd, ddr_wr, wt, vl, timeout_err}), 128'({2'b00, 3'b111, 3'b000, 1'b0}));
    @(negedge clk_sys);
    RESET = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    if (v.rst) do_reset();
    @(negedge clk_sys);
    rd = v.rd; wr = v.wr; bst = v.bst; busy = v.busy; dvalid = v.valid;
    ddr_dout = {$urandom, $urandom};
    #1;
    check({tag, " ctl"}, 128'({ddr_rd, ddr_wr, wt, vl, timeout_err}), 128'({v.cmd, v.wt, v.vl, v.err}));
    check({tag, " dout"}, 128'(req_dout), 128'(ddr_dout));
    if (v.chk)
      check({tag, " mux"}, 128'({ddr_addr, ddr_din, ddr_mask, ddr_burst}),
            128'({c_addr[v.g], c_din[v.g], c_mask[v.g], v.ebst}));
  endtask

  task automatic run_one(input logic [2:0] r, input logic [2:0] w, input logic [7:0] b,
                         input logic va, input logic [1:0] cmd, input logic [2:0] wte,
                         input logic [2:0] vle, input logic erre, input string tag);
    vec_t v;
    v.tid = 0; v.rst = 1'b0; v.rd = r; v.wr = w; v.bst = b; v.busy = 1'b0; v.valid = va;
    v.cmd = cmd; v.wt = wte; v.vl = vle; v.err = erre; v.chk = 1'b0; v.g = 2'd0; v.ebst = '0;
    apply(v, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    c_addr = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
    c_din  = '{64'hD000_0000_0000_00A0, 64'hD111_1111_1111_11A1, 64'hD222_2222_2222_22A2};
    c_mask = '{8'h0F, 8'hF0, 8'hA5};
    rd = '0; wr = '0; bst = '0; busy = 1'b0; dvalid = 1'b0; ddr_dout = '0;

    // 1: single 4-beat read by requester 2, extra valid in IDLE dropped
    add(1, 1, 3'b100, 3'b000, 8'd4, 0, 0, 2'b00, 3'b111, 3'b000, 0, 0, 0, 0);
    add(1, 0, 3'b100, 3'b000, 8'd4, 0, 0, 2'b10, 3'b011, 3'b000, 0, 1, 2, 8'd4);
    add(1, 0, 3'b000, 3'b000, 8'd4, 0, 1, 2'b00, 3'b111, 3'b100, 0, 0, 0, 0);
    add(1, 0, 3'b000, 3'b000, 8'd4, 0, 1, 2'b00, 3'b111, 3'b100, 0, 0, 0, 0);
    add(1, 0, 3'b000, 3'b000, 8'd4, 0, 0, 2'b00, 3'b111, 3'b000, 0, 0, 0, 0);
    add(1, 0, 3'b000, 3'b000, 8'd4, 0, 1, 2'b00, 3'b111, 3'b100, 0, 0, 0, 0);
    add(1, 0, 3'b000, 3'b000, 8'd4, 0, 1, 2'b00, 3'b111, 3'b100, 0, 0, 0, 0);
    add(1, 0, 3'b000, 3'b000, 8'd4, 0, 1, 2'b00, 3'b111, 3'b000, 0, 0, 0, 0);

    // 2: 8-beat write by requester 1, stall on beat 3, wr gap, burst input changed mid-burst
    add(2, 1, 3'b000, 3'b010, 8'd8, 0, 0, 2'b00, 3'b111, 3'b000, 0, 0, 0, 0);
    add(2, 0, 3'b000, 3'b010, 8'd8, 0, 0, 2'b01, 3'b101, 3'b000, 0, 1, 1, 8'd8);
    add(2, 0, 3'b000, 3'b010, 8'h55, 0, 0, 2'b01, 3'b101, 3'b000, 0, 1, 1, 8'd8);
    add(2, 0, 3'b000, 3'b010, 8'h55, 1, 0, 2'b01, 3'b111, 3'b000, 0, 1, 1, 8'd8);
    add(2, 0, 3'b000, 3'b010, 8'h55, 1, 0, 2'b01, 3'b111, 3'b000, 0, 1, 1, 8'd8);
    add(2, 0, 3'b000, 3'b010, 8'h55, 0, 0, 2'b01, 3'b101, 3'b000, 0, 1, 1, 8'd8);
    add(2, 0, 3'b000, 3'b000, 8'h55, 0, 0, 2'b00, 3'b101, 3'b000, 0, 1, 1, 8'd8);
    for (int k = 0; k < 5; k++)
      add(2, 0, 3'b000, 3'b010, 8'h55, 0, 0, 2'b01, 3'b101, 3'b000, 0, 1, 1, 8'd8);
    add(2, 0, 3'b000, 3'b000, 8'h55, 0, 0, 2'b00, 3'b111, 3'b000, 0, 0, 0, 0);

    // 3: all three issue single-beat reads continuously, grants go 0,1,2,0,1,2
    for (int k = 0; k < 6; k++) begin
      logic [2:0] m;
      m = 3'b001 << (k % 3);
      add(3, k == 0, 3'b111, 3'b000, 8'd1, 0, 1, 2'b00, 3'b111, 3'b000, 0, 0, 0, 0);
      add(3, 0, 3'b111, 3'b000, 8'd1, 0, 1, 2'b10, ~m, 3'b000, 0, 1, 2'(k % 3), 8'd1);
      add(3, 0, 3'b111, 3'b000, 8'd1, 0, 1, 2'b00, 3'b111, m, 0, 0, 0, 0);
    end

    // 4: 16-beat write by 0, requester 2 reads from beat 5 and must wait, then wins
    add(4, 1, 3'b000, 3'b001, 8'd16, 0, 0, 2'b00, 3'b111, 3'b000, 0, 0, 0, 0);
    add(4, 0, 3'b000, 3'b001, 8'd16, 0, 0, 2'b01, 3'b110, 3'b000, 0, 1, 0, 8'd16);
    for (int k = 2; k <= 16; k++)
      add(4, 0, (k >= 5) ? 3'b100 : 3'b000, 3'b001, 8'd16, 0, 0, 2'b01, 3'b110, 3'b000, 0, 1, 0, 8'd16);
    add(4, 0, 3'b100, 3'b001, 8'd1, 0, 0, 2'b00, 3'b111, 3'b000, 0, 0, 0, 0);
    add(4, 0, 3'b100, 3'b001, 8'd1, 0, 0, 2'b10, 3'b011, 3'b000, 0, 1, 2, 8'd1);
    add(4, 0, 3'b000, 3'b001, 8'd1, 0, 1, 2'b00, 3'b111, 3'b100, 0, 0, 0, 0);
    add(4, 0, 3'b000, 3'b001, 8'd1, 0, 0, 2'b00, 3'b111, 3'b000, 0, 0, 0, 0);
    add(4, 0, 3'b000, 3'b001, 8'd1, 0, 0, 2'b01, 3'b110, 3'b000, 0, 1, 0, 8'd1);
    add(4, 0, 3'b000, 3'b000, 8'd1, 0, 0, 2'b00, 3'b111, 3'b000, 0, 0, 0, 0);

    // 5: burst 0 read by requester 1 behaves as a single beat
    add(5, 1, 3'b010, 3'b000, 8'd0, 0, 0, 2'b00, 3'b111, 3'b000, 0, 0, 0, 0);
    add(5, 0, 3'b010, 3'b000, 8'd0, 0, 0, 2'b10, 3'b101, 3'b000, 0, 0, 0, 0);
    add(5, 0, 3'b000, 3'b000, 8'd0, 0, 1, 2'b00, 3'b111, 3'b010, 0, 0, 0, 0);
    add(5, 0, 3'b000, 3'b000, 8'd0, 0, 1, 2'b00, 3'b111, 3'b000, 0, 0, 0, 0);
    add(5, 0, 3'b000, 3'b000, 8'd0, 0, 1, 2'b00, 3'b111, 3'b000, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("t%0d.v%0d", vecs[i].tid, i));

    // reset asserted mid-read after 2 of 4 valids
    do_reset();
    run_one(3'b010, 3'b000, 8'd4, 0, 2'b00, 3'b111, 3'b000, 0, "rst idle");
    run_one(3'b010, 3'b000, 8'd4, 0, 2'b10, 3'b101, 3'b000, 0, "rst cmd");
    run_one(3'b000, 3'b000, 8'd4, 1, 2'b00, 3'b111, 3'b010, 0, "rst beat1");
    run_one(3'b000, 3'b000, 8'd4, 1, 2'b00, 3'b111, 3'b010, 0, "rst beat2");
    @(negedge clk_sys);
    dvalid = 1'b1; RESET = 1'b1;
    #1;
    check("rst async", 128'({ddr_rd, ddr_wr, wt, vl, timeout_err}), 128'({2'b00, 3'b111, 3'b000, 1'b0}));
    @(negedge clk_sys);
    RESET = 1'b0;
    run_one(3'b000, 3'b000, 8'd4, 1, 2'b00, 3'b111, 3'b000, 0, "rst late3");
    run_one(3'b000, 3'b000, 8'd4, 1, 2'b00, 3'b111, 3'b000, 0, "rst late4");
    run_one(3'b110, 3'b000, 8'd1, 0, 2'b00, 3'b111, 3'b000, 0, "rst rearb idle");
    run_one(3'b110, 3'b000, 8'd1, 0, 2'b10, 3'b101, 3'b000, 0, "rst rearb cmd");

`ifdef DDR_ARB_TIMEOUT_EN
    // watchdog: 4-beat read with only one valid times out on READ cycle 16
    do_reset();
    run_one(3'b100, 3'b000, 8'd4, 0, 2'b00, 3'b111, 3'b000, 0, "wd idle");
    run_one(3'b100, 3'b000, 8'd4, 0, 2'b10, 3'b011, 3'b000, 0, "wd cmd");
    run_one(3'b000, 3'b000, 8'd4, 1, 2'b00, 3'b111, 3'b100, 0, "wd beat1");
    for (int k = 2; k <= 16; k++)
      run_one(3'b000, 3'b000, 8'd4, 0, 2'b00, 3'b111, 3'b000, 0, $sformatf("wd read%0d", k));
    run_one(3'b001, 3'b000, 8'd4, 1, 2'b00, 3'b111, 3'b000, 1, "wd expired");
    run_one(3'b001, 3'b000, 8'd4, 0, 2'b10, 3'b110, 3'b000, 1, "wd next cmd");
    run_one(3'b000, 3'b000, 8'd4, 1, 2'b00, 3'b111, 3'b001, 1, "wd next beat");
`else
    // no watchdog: a read waits as long as the DDR takes
    do_reset();
    run_one(3'b100, 3'b000, 8'd2, 0, 2'b00, 3'b111, 3'b000, 0, "nowd idle");
    run_one(3'b100, 3'b000, 8'd2, 0, 2'b10, 3'b011, 3'b000, 0, "nowd cmd");
    run_one(3'b000, 3'b000, 8'd2, 1, 2'b00, 3'b111, 3'b100, 0, "nowd beat1");
    for (int k = 0; k < 40; k++)
      run_one(3'b000, 3'b000, 8'd2, 0, 2'b00, 3'b111, 3'b000, 0, $sformatf("nowd gap%0d", k));
    run_one(3'b000, 3'b000, 8'd2, 1, 2'b00, 3'b111, 3'b100, 0, "nowd beat2");
    run_one(3'b000, 3'b000, 8'd2, 1, 2'b00, 3'b111, 3'b000, 0, "nowd extra");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddr_arbiter.md
Name: ddr_arbiter

Overview:
- Shares the single DDRAM port (Avalon-style: busy/waitrequest, burst count, read-valid) between three requesters.
  - Requester 0: ROM download writer.
  - Requester 1: frame buffer writer.
  - Requester 2: ROM/tile reader.
- Sits between the Main datapath clients and the DDRAM_* pins, all in the clk_sys domain.
- Round-robin arbitration, burst-atomic: a grant is held until the whole burst completes.

Parameters:
- ADDR_WIDTH, 32, byte address width of requesters and DDR.
- DATA_WIDTH, 64, data bus width.
- BURST_WIDTH, 8, burst count width.
- TIMEOUT_CYCLES, 1024, read-burst watchdog limit (used only with DDR_ARB_TIMEOUT_EN).

Ports:
- clk_sys  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- req_rd[i]  in  1  read request, requester i (i=0..2, three separate ports each below)
- req_wr[i]  in  1  write request
- req_addr[i]  in  ADDR_WIDTH  byte address
- req_burst[i]  in  BURST_WIDTH  burst length (0 treated as 1)
- req_din[i]  in  DATA_WIDTH  write data
- req_mask[i]  in  DATA_WIDTH/8  byte enables
- req_wait[i]  out  1  wait request to requester i
- req_valid[i]  out  1  read data valid to requester i
- req_dout  out  DATA_WIDTH  read data, broadcast to all requesters
- ddr_rd, ddr_wr  out  1  DDR command strobes
- ddr_addr  out  ADDR_WIDTH  DDR address
- ddr_burst  out  BURST_WIDTH  DDR burst count
- ddr_din  out  DATA_WIDTH  DDR write data
- ddr_mask  out  DATA_WIDTH/8  DDR byte enables
- ddr_busy  in  1  DDR waitrequest
- ddr_valid  in  1  DDR read data valid
- ddr_dout  in  DATA_WIDTH  DDR read data
- timeout_err  out  1  sticky watchdog flag (tied 0 without macro)

Behaviour:
- Reset values:
  - state=IDLE, grant=0, last_grant=2 (so requester 0 wins first).
  - ddr_rd=0, ddr_wr=0; all req_wait=1, all req_valid=0.
  - counter=0, timeout_err=0.
- Request: requester i has a request when req_rd[i]|req_wr[i]. If both are set, rd wins.
- IDLE:
  - req_wait all 1; ddr_rd/ddr_wr 0.
  - If any request: grant = first requester after last_grant in cyclic order 0→1→2→0. Register grant and last_grant; go to CMD.
  - Arbitration latency is exactly 1 cycle.
- CMD:
  - DDR outputs are combinationally muxed from the granted requester.
  - req_wait[grant] = ddr_busy; all other req_wait=1.
  - Read accepted (ddr_rd & ~ddr_busy): latch counter = max(burst,1); go to READ.
  - Write accepted (ddr_wr & ~ddr_busy): counter = max(burst,1)-1. If the result is 0, go to IDLE; otherwise go to WRITE.
  - Granted requester drops both rd and wr: go to IDLE next cycle, no DDR transfer.
- READ:
  - ddr_rd=0; all req_wait=1.
  - req_valid[grant] = ddr_valid; other req_valid=0.
  - Each ddr_valid decrements counter. On the valid that takes counter 1→0, go to IDLE in the same cycle edge.
  - Extra ddr_valid arriving in IDLE is dropped; req_valid stays 0.
- WRITE:
  - Mux as in CMD; ddr_burst keeps the latched first-beat value.
  - Each accepted beat decrements counter; at 0, go to IDLE.
  - Deasserted ddr_wr mid-burst: hold state, no decrement.
- req_dout = ddr_dout at all times.
- Back-to-back:
  - Minimum 1 IDLE cycle between bursts.
  - With all three requesting continuously, grant sequence is 0,1,2,0…
  - No requester is starved for more than 2 bursts.
- Reset mid-burst: immediate return to reset values. An outstanding DDR burst is abandoned; its late valids are dropped in IDLE.

Optional Feature:
- Macro DDR_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in READ and clears on entry.
  - If it reaches TIMEOUT_CYCLES before the burst completes: force IDLE, set timeout_err=1 (sticky until RESET).
- Undefined: no watchdog; READ waits indefinitely; timeout_err tied 0.

Test Plan:
1. Single read: req_rd[2]=1, addr 0x3000_0000, burst 4, ddr_busy=0, 4 valids → ddr_rd high 1 cycle at cycle 1; req_valid[2] pulses 4×; IDLE after 4th valid; req_valid[0..1] stay 0.
2. Write burst with stall: req_wr[1], burst 8, ddr_busy high on beats 3–4 → exactly 8 accepted beats, ddr_burst=8 throughout, req_wait[1] mirrors ddr_busy, return to IDLE.
3. Round-robin: all three request single-beat reads continuously → grant order 0,1,2,0,1,2; each burst separated by 1 IDLE cycle.
4. Contention: req_wr[0] burst 16 in progress, req_rd[2] asserted mid-burst → req_wait[2]=1 until all 16 beats are accepted, then requester 2 is granted next.
5. Burst 0 and reset: req_rd[1] burst 0 → treated as 1 beat. RESET asserted during a READ with 2 of 4 valids received → all outputs at reset values immediately; remaining 2 valids are not forwarded.
6. DDR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: read burst 4 with only 1 valid → IDLE at cycle 16 of READ, timeout_err=1, next request granted normally.
